// File: rtl/in_debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : in_debounce_pkg
//  Purpose  : Shared types, default constants and counter-width helper for
//             the in_debounce input conditioning stage.
//  Revision : 1.0 - initial release
// ============================================================================
package in_debounce_pkg;

    // Debounce FSM state encoding
    typedef logic [0:0] state_t;
    localparam state_t c_STABLE  = 1'b0;
    localparam state_t c_PENDING = 1'b1;

    // Default configuration
    localparam int   c_DEF_SYNC_STAGES     = 2;
    localparam int   c_DEF_DEBOUNCE_CYCLES = 16;
    localparam logic c_DEF_RESET_LEVEL     = 1'b0;

    // Width of the qualification counter for a given debounce length
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/in_debounce_if.sv
`default_nettype none
// ============================================================================
//  Module   : in_debounce_if
//  Purpose  : Signal bundle between a raw input source / consumer and the
//             in_debounce stage.
//  Revision : 1.0 - initial release
// ============================================================================
interface in_debounce_if;
    logic IN_RAW;   // raw asynchronous level
    logic EN;       // sample tick
    logic IN;       // debounced level
    logic RISE;     // 0->1 pulse on IN
    logic FALL;     // 1->0 pulse on IN
    logic BUSY;     // level change pending

    // Source side: drives the raw level and tick, consumes the clean outputs
    modport master (output IN_RAW, EN, input IN, RISE, FALL, BUSY);
    // Debouncer side
    modport slave  (input IN_RAW, EN, output IN, RISE, FALL, BUSY);
endinterface
`default_nettype wire

// File: rtl/in_debounce_sync_ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_ff
//  Purpose  : N-flop level synchroniser with synchronous active-high reset
//             and configurable reset value. Reusable for any asynchronous
//             single-bit input.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  wire logic CLK,
    input  wire logic RST,
    input  wire logic i_d,
    output logic      o_q
);

    logic [STAGES-1:0] r_sync;

    // Shift the raw level through the chain; bit 0 is the metastable stage
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync <= {STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/in_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : in_debounce
//  Purpose  : Synchronise a raw asynchronous level into CLK and debounce it
//             with a consecutive-sample counter. Produces a clean IN level,
//             a BUSY flag while a change is qualifying and, optionally,
//             single-cycle RISE/FALL pulses.
//  Config   : define IN_DEBOUNCE_PULSE_EN to build the RISE/FALL pulse
//             logic; otherwise RISE/FALL are tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module in_debounce
    import in_debounce_pkg::*;
#(
    parameter int   SYNC_STAGES     = c_DEF_SYNC_STAGES,
    parameter int   DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES,
    parameter logic RESET_LEVEL     = c_DEF_RESET_LEVEL
) (
    input  wire logic    CLK,
    input  wire logic    RST,
    in_debounce_if.slave bus
);

    localparam int                 c_CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic               w_s;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               r_in;
    logic               w_in_nxt;
    logic               r_busy;

    sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (RESET_LEVEL)
    ) u_sync (
        .CLK (CLK),
        .RST (RST),
        .i_d (bus.IN_RAW),
        .o_q (w_s)
    );

    // Next-state logic: qualify a disagreement between s and IN over
    // DEBOUNCE_CYCLES enabled samples; any agreement restarts from zero
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_in_nxt    = r_in;
        case (r_state)
            c_STABLE: begin
                if (w_s == r_in) begin
                    w_cnt_nxt = '0;
                end else if (bus.EN) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        w_in_nxt = w_s;
                    end else begin
                        w_cnt_nxt   = c_CNT_ONE;
                        w_state_nxt = c_PENDING;
                    end
                end else begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_PENDING;
                end
            end
            c_PENDING: begin
                if (w_s == r_in) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_STABLE;
                end else if (bus.EN) begin
                    if (r_cnt == c_CNT_LAST) begin
                        w_in_nxt    = w_s;
                        w_cnt_nxt   = '0;
                        w_state_nxt = c_STABLE;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = c_STABLE;
            end
        endcase
    end

    // State, counter, debounced level and BUSY registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_STABLE;
            r_cnt   <= '0;
            r_in    <= RESET_LEVEL;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_in    <= w_in_nxt;
            r_busy  <= (w_state_nxt == c_PENDING);
        end
    end

    assign bus.IN   = r_in;
    assign bus.BUSY = r_busy;

`ifdef IN_DEBOUNCE_PULSE_EN
    logic r_rise;
    logic r_fall;

    // Edge pulses registered on the same edge that IN changes; reset forces
    // them low so reset entry/exit never produces a pulse
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= ~r_in &  w_in_nxt;
            r_fall <=  r_in & ~w_in_nxt;
        end
    end

    assign bus.RISE = r_rise;
    assign bus.FALL = r_fall;
`else
    assign bus.RISE = 1'b0;
    assign bus.FALL = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_in_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : tb_in_debounce
//  Purpose  : Self-checking bench for in_debounce (DEBOUNCE_CYCLES=4 and =1).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_in_debounce;

`ifdef IN_DEBOUNCE_PULSE_EN
    localparam bit c_PE = 1'b1;
`else
    localparam bit c_PE = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   errors = 0;
    int   checks = 0;

    // Expected {IN, RISE, FALL, BUSY} per clock edge
    logic [3:0] exp_q[$];

    always #5 CLK = ~CLK;

    in_debounce_if bus4 ();
    in_debounce_if bus1 ();

    in_debounce #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .RESET_LEVEL     (1'b0)
    ) u_dut4 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus4)
    );

    in_debounce #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (1),
        .RESET_LEVEL     (1'b0)
    ) u_dut1 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus1)
    );

    function automatic logic [3:0] obs4();
        return {bus4.IN, bus4.RISE, bus4.FALL, bus4.BUSY};
    endfunction

    function automatic logic [3:0] obs1();
        return {bus1.IN, bus1.RISE, bus1.FALL, bus1.BUSY};
    endfunction

    task automatic test_reset();
        logic [3:0] e;
        logic [3:0] o;
        RST = 1'b1;
        bus4.IN_RAW = 1'b1; bus4.EN = 1'b1;
        bus1.IN_RAW = 1'b1; bus1.EN = 1'b1;
        for (int ed = 1; ed <= 6; ed++) begin
            if (ed == 4) begin
                RST = 1'b0;
                bus4.IN_RAW = 1'b0;
                bus1.IN_RAW = 1'b0;
            end
            exp_q.push_back(4'b0000);
            @(posedge CLK); #1;
            e = exp_q.pop_front();
            o = obs4();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset dut4 edge %0d: got %b want %b", ed, o, e);
            end
            o = obs1();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset dut1 edge %0d: got %b want %b", ed, o, e);
            end
        end
    endtask

    task automatic test_glitch();
        logic [3:0] e;
        logic [3:0] o;
        bus4.IN_RAW = 1'b1;
        for (int ed = 1; ed <= 8; ed++) begin
            if (ed == 3) bus4.IN_RAW = 1'b0;
            exp_q.push_back({1'b0, 1'b0, 1'b0, (ed >= 3 && ed <= 4)});
            @(posedge CLK); #1;
            e = exp_q.pop_front();
            o = obs4();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL glitch edge %0d: IN/RISE/FALL/BUSY got %b want %b", ed, o, e);
            end
        end
    endtask

    task automatic test_reset_mid_pending();
        logic [3:0] e;
        logic [3:0] o;
        bus4.IN_RAW = 1'b1;
        for (int ed = 1; ed <= 12; ed++) begin
            if (ed == 4) RST = 1'b1;
            if (ed == 5) RST = 1'b0;
            exp_q.push_back({(ed >= 10), (c_PE && ed == 10), 1'b0,
                             (ed == 3 || (ed >= 7 && ed <= 9))});
            @(posedge CLK); #1;
            e = exp_q.pop_front();
            o = obs4();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_mid edge %0d: IN/RISE/FALL/BUSY got %b want %b", ed, o, e);
            end
        end
    endtask

    task automatic test_fall();
        logic [3:0] e;
        logic [3:0] o;
        bus4.IN_RAW = 1'b0;
        for (int ed = 1; ed <= 8; ed++) begin
            exp_q.push_back({(ed < 6), 1'b0, (c_PE && ed == 6), (ed >= 3 && ed <= 5)});
            @(posedge CLK); #1;
            e = exp_q.pop_front();
            o = obs4();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL fall edge %0d: IN/RISE/FALL/BUSY got %b want %b", ed, o, e);
            end
        end
    endtask

    task automatic test_enable_gating();
        logic [3:0] e;
        logic [3:0] o;
        bus4.IN_RAW = 1'b1;
        for (int ed = 1; ed <= 14; ed++) begin
            bus4.EN = (ed % 3 == 0);
            exp_q.push_back({(ed >= 12), (c_PE && ed == 12), 1'b0, (ed >= 3 && ed <= 11)});
            @(posedge CLK); #1;
            e = exp_q.pop_front();
            o = obs4();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL enable_gating edge %0d: IN/RISE/FALL/BUSY got %b want %b", ed, o, e);
            end
        end
        bus4.EN = 1'b1;
    endtask

    task automatic test_reset_from_high();
        logic [3:0] e;
        logic [3:0] o;
        bus4.IN_RAW = 1'b0;
        RST = 1'b1;
        for (int ed = 1; ed <= 5; ed++) begin
            if (ed == 2) RST = 1'b0;
            exp_q.push_back(4'b0000);
            @(posedge CLK); #1;
            e = exp_q.pop_front();
            o = obs4();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_from_high edge %0d: IN/RISE/FALL/BUSY got %b want %b", ed, o, e);
            end
        end
    endtask

    task automatic test_clean_rise();
        logic [3:0] e;
        logic [3:0] o;
        bus4.IN_RAW = 1'b1;
        for (int ed = 1; ed <= 8; ed++) begin
            exp_q.push_back({(ed >= 6), (c_PE && ed == 6), 1'b0, (ed >= 3 && ed <= 5)});
            @(posedge CLK); #1;
            e = exp_q.pop_front();
            o = obs4();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL clean_rise edge %0d: IN/RISE/FALL/BUSY got %b want %b", ed, o, e);
            end
        end
    endtask

    task automatic test_single_cycle();
        logic [3:0] e;
        logic [3:0] o;
        for (int ph = 0; ph < 2; ph++) begin
            bus1.IN_RAW = (ph == 0);
            for (int ed = 1; ed <= 5; ed++) begin
                if (ph == 0)
                    exp_q.push_back({(ed >= 3), (c_PE && ed == 3), 1'b0, 1'b0});
                else
                    exp_q.push_back({(ed < 3), 1'b0, (c_PE && ed == 3), 1'b0});
                @(posedge CLK); #1;
                e = exp_q.pop_front();
                o = obs1();
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL dc1 phase %0d edge %0d: IN/RISE/FALL/BUSY got %b want %b", ph, ed, o, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_reset_mid_pending();
        test_fall();
        test_enable_gating();
        test_reset_from_high();
        test_clean_rise();
        test_single_cycle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
